// File: rtl/nibble_serial_add_sched.sv
// Two-requester scheduler that time-shares one 4-bit carry-lookahead slice,
// walking it across WIDTH/4 nibbles per add and returning a tagged sum.
module nibble_serial_add_sched #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [WIDTH-1:0] req0_a_i,
   input  logic [WIDTH-1:0] req0_b_i,
   input  logic             req0_cin_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [WIDTH-1:0] req1_a_i,
   input  logic [WIDTH-1:0] req1_b_i,
   input  logic             req1_cin_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_id_o,
   output logic [WIDTH-1:0] resp_sum_o,
   output logic             resp_cout_o,
   output logic             busy_o
);

   localparam int NIB = WIDTH / 4;
   localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

   state_e           state_q, state_d;
   logic             lastGrant_q;
   logic [WIDTH-1:0] aOp_q, bOp_q, sum_q;
   logic             carry_q, id_q;
   logic [KW-1:0]    nibIdx_q;

   logic             accept0, accept1, lastNib;
   logic [3:0]       nibA, nibB, nibP, nibG, nibSum;
   logic [4:0]       nibC;

   assign accept0 = req0_valid_i & req0_ready_o;
   assign accept1 = req1_valid_i & req1_ready_o;
   assign lastNib = (nibIdx_q == KW'(NIB - 1));

   // Shared slice: full lookahead carries for the nibble selected by nibIdx_q
   always_comb begin
      nibA    = aOp_q[{nibIdx_q, 2'b00} +: 4];
      nibB    = bOp_q[{nibIdx_q, 2'b00} +: 4];
      nibP    = nibA ^ nibB;
      nibG    = nibA & nibB;
      nibC[0] = carry_q;
      nibC[1] = nibG[0] | (nibP[0] & nibC[0]);
      nibC[2] = nibG[1] | (nibP[1] & nibG[0]) | (nibP[1] & nibP[0] & nibC[0]);
      nibC[3] = nibG[2] | (nibP[2] & nibG[1]) | (nibP[2] & nibP[1] & nibG[0])
              | (nibP[2] & nibP[1] & nibP[0] & nibC[0]);
      nibC[4] = nibG[3] | (nibP[3] & nibG[2]) | (nibP[3] & nibP[2] & nibG[1])
              | (nibP[3] & nibP[2] & nibP[1] & nibG[0])
              | (nibP[3] & nibP[2] & nibP[1] & nibP[0] & nibC[0]);
      nibSum  = nibP ^ nibC[3:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept0 | accept1) state_d = RUN;
         RUN:     if (lastNib)           state_d = RESP;
         RESP:    if (resp_ready_i)      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ties go to whichever requester was not served last
   always_comb begin
      req0_ready_o = (state_q == IDLE) & (lastGrant_q | ~req1_valid_i);
      req1_ready_o = (state_q == IDLE) & (~lastGrant_q | ~req0_valid_i);
      resp_valid_o = (state_q == RESP);
      busy_o       = (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastGrant_q <= 1'b1;
         aOp_q       <= '0;
         bOp_q       <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         id_q        <= 1'b0;
         nibIdx_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept0 | accept1) begin
                  aOp_q       <= accept1 ? req1_a_i : req0_a_i;
                  bOp_q       <= accept1 ? req1_b_i : req0_b_i;
                  carry_q     <= accept1 ? req1_cin_i : req0_cin_i;
                  id_q        <= accept1;
                  lastGrant_q <= accept1;
                  nibIdx_q    <= '0;
               end
            end
            RUN: begin
               sum_q[{nibIdx_q, 2'b00} +: 4] <= nibSum;
               carry_q  <= nibC[4];
               nibIdx_q <= lastNib ? '0 : nibIdx_q + KW'(1);
            end
            default: ;
         endcase
      end
   end

   // After the last nibble the carry register is the sum's carry-out
   assign resp_sum_o  = sum_q;
   assign resp_cout_o = carry_q;
   assign resp_id_o   = id_q;

endmodule

// File: tb/tb_nibble_serial_add_sched.sv
// Scenario bench for nibble_serial_add_sched; expectations come from plain
// integer addition and a transaction-level model of arbitration and latency.
module tb_nibble_serial_add_sched;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;
   localparam int LAT   = NIB + 1;

   typedef struct {
      logic             id;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
   } txn_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req0_valid_i = 1'b0, req1_valid_i = 1'b0;
   logic             req0_ready_o, req1_ready_o;
   logic [WIDTH-1:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
   logic             req0_cin_i = 1'b0, req1_cin_i = 1'b0;
   logic             resp_valid_o, resp_id_o, resp_cout_o, busy_o;
   logic             resp_ready_i = 1'b0;
   logic [WIDTH-1:0] resp_sum_o;

   int nChecks = 0;
   int nFails  = 0;
   int cycle   = 0;

   nibble_serial_add_sched #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
      .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_cin_i(req0_cin_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
      .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_cin_i(req1_cin_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_id_o(resp_id_o), .resp_sum_o(resp_sum_o),
      .resp_cout_o(resp_cout_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle = cycle + 1;

   function automatic logic [WIDTH:0] refAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin);
      return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
   endfunction

   task automatic driveReq(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin);
      if (id == 1'b0) begin
         req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; req0_cin_i = cin;
      end else begin
         req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; req1_cin_i = cin;
      end
   endtask

   task automatic dropReq(input bit id);
      if (id == 1'b0) req0_valid_i = 1'b0;
      else            req1_valid_i = 1'b0;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0; resp_ready_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Presents a request and waits (bounded) for it to be taken; returns on the next negedge
   task automatic issue(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, output int accCyc, output bit ok);
      driveReq(id, a, b, cin);
      ok = 1'b0; accCyc = -1;
      for (int i = 0; i < 40 && !ok; i++) begin
         #1;
         if ((id == 1'b0 && req0_ready_o) || (id == 1'b1 && req1_ready_o)) begin
            accCyc = cycle; ok = 1'b1;
         end
         @(negedge clk);
      end
      dropReq(id);
   endtask

   task automatic waitResp(output logic [WIDTH-1:0] sum, output logic cout, output logic id,
                           output int respCyc, output bit ok);
      ok = 1'b0; respCyc = -1; sum = '0; cout = 1'b0; id = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         #1;
         if (resp_valid_o) begin
            sum = resp_sum_o; cout = resp_cout_o; id = resp_id_o;
            respCyc = cycle; ok = 1'b1; resp_ready_i = 1'b1;
         end
         @(negedge clk);
      end
      resp_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk); #1;
      nChecks++; if (resp_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL rst_resp_valid: got %b, expected 0", resp_valid_o); end
      nChecks++; if (busy_o !== 1'b0) begin nFails++; $display("[TB] FAIL rst_busy: got %b, expected 0", busy_o); end
      nChecks++; if (resp_sum_o !== '0) begin nFails++; $display("[TB] FAIL rst_sum: got %h, expected 0", resp_sum_o); end
      nChecks++; if (resp_cout_o !== 1'b0 || resp_id_o !== 1'b0) begin nFails++; $display("[TB] FAIL rst_cout_id: got %b/%b, expected 0/0", resp_cout_o, resp_id_o); end
      req0_valid_i = 1'b1; req1_valid_i = 1'b1;
      #1;
      nChecks++; if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin nFails++; $display("[TB] FAIL rst_tie_readys: got %b%b, expected 10", req0_ready_o, req1_ready_o); end
      @(negedge clk);
      req0_valid_i = 1'b0; req1_valid_i = 1'b0; rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_add();
      int acc; bit ok; logic [WIDTH:0] r;
      r = refAdd(16'h1234, 16'h0FCD, 1'b0);
      issue(1'b0, 16'h1234, 16'h0FCD, 1'b0, acc, ok);
      nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL single_accept: got timeout, expected accept"); end
      for (int k = 1; k <= LAT; k++) begin
         #1;
         nChecks++; if (busy_o !== 1'b1) begin nFails++; $display("[TB] FAIL single_busy_T+%0d: got %b, expected 1", k, busy_o); end
         nChecks++; if (resp_valid_o !== (k == LAT)) begin nFails++; $display("[TB] FAIL single_valid_T+%0d: got %b, expected %b", k, resp_valid_o, (k == LAT)); end
         if (k < LAT) @(negedge clk);
      end
      nChecks++; if (resp_sum_o !== 16'h2201 || resp_sum_o !== r[WIDTH-1:0]) begin nFails++; $display("[TB] FAIL single_sum: got %h, expected 2201", resp_sum_o); end
      nChecks++; if (resp_cout_o !== 1'b0 || resp_id_o !== 1'b0) begin nFails++; $display("[TB] FAIL single_cout_id: got %b/%b, expected 0/0", resp_cout_o, resp_id_o); end
      resp_ready_i = 1'b1;
      @(negedge clk);
      resp_ready_i = 1'b0; #1;
      nChecks++; if (busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL single_idle: got busy=%b valid=%b, expected 0/0", busy_o, resp_valid_o); end
      @(negedge clk);
   endtask

   task automatic test_carry_ripple();
      logic [WIDTH-1:0] aTab [2] = '{16'hFFFF, 16'hFFFF};
      logic [WIDTH-1:0] bTab [2] = '{16'h0000, 16'hFFFF};
      logic [WIDTH-1:0] sTab [2] = '{16'h0000, 16'hFFFF};
      logic [WIDTH:0] r; logic [WIDTH-1:0] s; logic c, id; int acc, rc; bit ok1, ok2;
      for (int i = 0; i < 2; i++) begin
         r = refAdd(aTab[i], bTab[i], 1'b1);
         issue(1'b1, aTab[i], bTab[i], 1'b1, acc, ok1);
         waitResp(s, c, id, rc, ok2);
         nChecks++; if (!(ok1 && ok2)) begin nFails++; $display("[TB] FAIL carry_%0d_handshake: got timeout, expected completion", i); end
         nChecks++; if (rc - acc != LAT) begin nFails++; $display("[TB] FAIL carry_%0d_latency: got %0d, expected %0d", i, rc - acc, LAT); end
         nChecks++; if (s !== sTab[i] || s !== r[WIDTH-1:0]) begin nFails++; $display("[TB] FAIL carry_%0d_sum: got %h, expected %h", i, s, sTab[i]); end
         nChecks++; if (c !== 1'b1 || id !== 1'b1) begin nFails++; $display("[TB] FAIL carry_%0d_cout_id: got %b/%b, expected 1/1", i, c, id); end
      end
   endtask

   task automatic test_round_robin();
      txn_t q[$]; int accCyc[$]; bit accId[$]; int nResp = 0; bit new0 = 0, new1 = 0;
      txn_t t; logic [WIDTH:0] r;
      resetDut();
      driveReq(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      driveReq(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      resp_ready_i = 1'b1;
      for (int i = 0; i < 80 && nResp < 4; i++) begin
         #1;
         if (resp_valid_o) begin
            nChecks++;
            if (q.size() == 0) begin nFails++; $display("[TB] FAIL rr_spurious: got response, expected none"); end
            else begin
               t = q.pop_front(); r = refAdd(t.a, t.b, t.cin);
               if (resp_id_o !== t.id || resp_sum_o !== r[WIDTH-1:0] || resp_cout_o !== r[WIDTH]) begin
                  nFails++; $display("[TB] FAIL rr_resp_%0d: got id=%b sum=%h c=%b, expected id=%b sum=%h c=%b",
                                     nResp, resp_id_o, resp_sum_o, resp_cout_o, t.id, r[WIDTH-1:0], r[WIDTH]);
               end
            end
            nResp++;
         end
         if (req0_valid_i && req0_ready_o) begin
            q.push_back('{1'b0, req0_a_i, req0_b_i, req0_cin_i}); accCyc.push_back(cycle); accId.push_back(1'b0); new0 = 1;
         end else if (req1_valid_i && req1_ready_o) begin
            q.push_back('{1'b1, req1_a_i, req1_b_i, req1_cin_i}); accCyc.push_back(cycle); accId.push_back(1'b1); new1 = 1;
         end
         @(negedge clk);
         if (new0) begin driveReq(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1))); new0 = 0; end
         if (new1) begin driveReq(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1))); new1 = 0; end
      end
      dropReq(1'b0); dropReq(1'b1); resp_ready_i = 1'b0;
      nChecks++; if (nResp != 4 || accId.size() < 4) begin nFails++; $display("[TB] FAIL rr_count: got %0d, expected 4", nResp); end
      for (int i = 0; i < 4 && i < accId.size(); i++) begin
         nChecks++; if (accId[i] !== 1'(i % 2)) begin nFails++; $display("[TB] FAIL rr_order_%0d: got %b, expected %b", i, accId[i], 1'(i % 2)); end
         if (i > 0) begin
            nChecks++; if (accCyc[i] - accCyc[i-1] != NIB + 2) begin nFails++; $display("[TB] FAIL rr_spacing_%0d: got %0d, expected %0d", i, accCyc[i] - accCyc[i-1], NIB + 2); end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] a, b, s; logic cin, c, id; logic [WIDTH:0] r; int acc, rc; bit ok, seen;
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom_range(0, 1));
      r = refAdd(a, b, cin);
      issue(1'b0, a, b, cin, acc, ok);
      driveReq(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         #1;
         if (resp_valid_o) seen = 1'b1;
         else @(negedge clk);
      end
      nChecks++; if (!(ok && seen)) begin nFails++; $display("[TB] FAIL bp_resp: got timeout, expected response"); end
      for (int i = 0; i < 4; i++) begin
         nChecks++; if (resp_valid_o !== 1'b1 || resp_sum_o !== r[WIDTH-1:0] || resp_cout_o !== r[WIDTH] || resp_id_o !== 1'b0) begin
            nFails++; $display("[TB] FAIL bp_hold_%0d: got v=%b sum=%h c=%b id=%b, expected 1/%h/%b/0", i, resp_valid_o, resp_sum_o, resp_cout_o, resp_id_o, r[WIDTH-1:0], r[WIDTH]);
         end
         nChecks++; if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin nFails++; $display("[TB] FAIL bp_readys_%0d: got %b%b, expected 00", i, req0_ready_o, req1_ready_o); end
         @(negedge clk); #1;
      end
      resp_ready_i = 1'b1;
      @(negedge clk);
      resp_ready_i = 1'b0; #1;
      nChecks++; if (busy_o !== 1'b0 || req1_ready_o !== 1'b1) begin nFails++; $display("[TB] FAIL bp_release: got busy=%b ready1=%b, expected 0/1", busy_o, req1_ready_o); end
      a = req1_a_i; b = req1_b_i; r = refAdd(a, b, 1'b0);
      @(negedge clk);
      dropReq(1'b1); #1;
      nChecks++; if (busy_o !== 1'b1) begin nFails++; $display("[TB] FAIL bp_pending_accept: got busy=%b, expected 1", busy_o); end
      waitResp(s, c, id, rc, ok);
      nChecks++; if (!ok || id !== 1'b1 || s !== r[WIDTH-1:0] || c !== r[WIDTH]) begin nFails++; $display("[TB] FAIL bp_pending_resp: got id=%b sum=%h, expected 1/%h", id, s, r[WIDTH-1:0]); end
   endtask

   task automatic test_reset_mid_run();
      logic [WIDTH-1:0] a0, b0, a1, b1, s; logic c, id; logic [WIDTH:0] r; int acc, rc; bit ok;
      issue(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b1, acc, ok);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b0; #1;
      nChecks++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || resp_sum_o !== '0 || resp_cout_o !== 1'b0 || resp_id_o !== 1'b0) begin
         nFails++; $display("[TB] FAIL midrst_outputs: got v=%b busy=%b sum=%h c=%b id=%b, expected all 0", resp_valid_o, busy_o, resp_sum_o, resp_cout_o, resp_id_o);
      end
      a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
      driveReq(1'b0, a0, b0, 1'b0); driveReq(1'b1, a1, b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b1; #1;
      nChecks++; if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_tie: got %b%b, expected 10", req0_ready_o, req1_ready_o); end
      @(negedge clk);
      dropReq(1'b0);
      waitResp(s, c, id, rc, ok);
      r = refAdd(a0, b0, 1'b0);
      nChecks++; if (!ok || id !== 1'b0 || s !== r[WIDTH-1:0] || c !== r[WIDTH]) begin nFails++; $display("[TB] FAIL midrst_first: got id=%b sum=%h, expected 0/%h", id, s, r[WIDTH-1:0]); end
      issue(1'b1, a1, b1, 1'b1, acc, ok);
      waitResp(s, c, id, rc, ok);
      r = refAdd(a1, b1, 1'b1);
      nChecks++; if (!ok || id !== 1'b1 || s !== r[WIDTH-1:0] || c !== r[WIDTH]) begin nFails++; $display("[TB] FAIL midrst_second: got id=%b sum=%h, expected 1/%h", id, s, r[WIDTH-1:0]); end
   endtask

   // Transaction-level model: one add in flight, response LAT cycles after acceptance
   task automatic test_random_sweep();
      txn_t q[$]; txn_t t; logic [WIDTH:0] r;
      bit busyM = 0, lgM = 1, expR0, expR1, expV, win, dropPend = 0;
      int accC = 0, done = 0;
      resetDut();
      for (int cyc = 0; cyc < 40000 && done < 1000; cyc++) begin
         if (!req0_valid_i && $urandom_range(0, 1) == 1)
            driveReq(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
         if (!req1_valid_i && $urandom_range(0, 1) == 1)
            driveReq(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
         resp_ready_i = ($urandom_range(0, 3) != 0);
         #1;
         expR0 = !busyM && (lgM || !req0_valid_i || !req1_valid_i);
         expR1 = !busyM && (!lgM || !req0_valid_i || !req1_valid_i);
         expR0 = expR0 && (lgM || !req1_valid_i);
         expR1 = expR1 && (!lgM || !req0_valid_i);
         expV  = busyM && (cycle - accC >= LAT);
         nChecks++; if (req0_ready_o !== expR0 || req1_ready_o !== expR1) begin nFails++; $display("[TB] FAIL sweep_readys@%0d: got %b%b, expected %b%b", cycle, req0_ready_o, req1_ready_o, expR0, expR1); end
         nChecks++; if (resp_valid_o !== expV) begin nFails++; $display("[TB] FAIL sweep_valid@%0d: got %b, expected %b", cycle, resp_valid_o, expV); end
         if (expV && q.size() > 0) begin
            t = q[0]; r = refAdd(t.a, t.b, t.cin);
            nChecks++; if (resp_id_o !== t.id || resp_sum_o !== r[WIDTH-1:0] || resp_cout_o !== r[WIDTH]) begin
               nFails++; $display("[TB] FAIL sweep_resp_%0d: got id=%b sum=%h c=%b, expected id=%b sum=%h c=%b",
                                  done, resp_id_o, resp_sum_o, resp_cout_o, t.id, r[WIDTH-1:0], r[WIDTH]);
            end
            if (resp_ready_i) begin void'(q.pop_front()); busyM = 0; done++; end
         end else if (!busyM && ((req0_valid_i && expR0) || (req1_valid_i && expR1))) begin
            win = req1_valid_i && expR1;
            if (win) q.push_back('{1'b1, req1_a_i, req1_b_i, req1_cin_i});
            else     q.push_back('{1'b0, req0_a_i, req0_b_i, req0_cin_i});
            busyM = 1; accC = cycle; lgM = win; dropPend = 1;
         end
         @(negedge clk);
         if (dropPend) begin dropReq(win); dropPend = 0; end
      end
      dropReq(1'b0); dropReq(1'b1); resp_ready_i = 1'b0;
      nChecks++; if (done != 1000) begin nFails++; $display("[TB] FAIL sweep_done: got %0d, expected 1000", done); end
   endtask

   initial begin
      $display("[TB] starting nibble_serial_add_sched bench");
      test_reset();
      test_single_add();
      test_carry_ripple();
      test_round_robin();
      test_backpressure();
      test_reset_mid_run();
      test_random_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
